mem_port_arbiter: RTL and testbench

- Shares the single ROM/RAM memory system between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Arbitrates between them, decodes the target region (RAM at and above RAM_BASE, ROM below it) and sequences one access at a time with a fixed per-region latency.
- Returns read data or a write acknowledge to the winning port.
- Sits between the CPU memory stages and the ROM/RAM macros.

---
 rtl/mem_sys_pkg.sv | 18 +
 rtl/mem_region_decode.sv | 16 +
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sys_pkg.sv
// Shared definitions for the memory-system arbiter.
//   RAM_BASE_DEFAULT : first RAM byte address; everything below is ROM
//   state_e          : arbiter sequencing states
//   PORT_FETCH/DATA  : requester indices (instruction fetch, data load/store)
package mem_sys_pkg;

  localparam logic [31:0] RAM_BASE_DEFAULT = 32'h0010_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/mem_region_decode.sv
// Region decoder: flags addresses that belong to RAM.
//   addr   : byte address to classify
//   is_ram : 1 when addr >= RAM_BASE (unsigned), including all-ones
module mem_region_decode
  import mem_sys_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = ADDR_WIDTH'(RAM_BASE_DEFAULT)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  is_ram
);

  assign is_ram = (addr >= RAM_BASE);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the ROM/RAM macros.
//   clk_i, rst_n_i           : clock, asynchronous active-low reset
//   pN_req/we/addr/wdata_i   : requester N command, held until pN_gnt_o
//   pN_gnt_o                 : combinational grant in IDLE; command captured on that edge
//   pN_rvalid/rdata/err_o    : one-cycle completion; err flags a write to ROM
//   rom_*                    : ROM read port
//   ram_*                    : RAM read/write port
//   busy_o                   : high whenever an access is in flight
// One access at a time: IDLE (grant) -> ACCESS (region latency) -> RESP -> IDLE.
module mem_port_arbiter
  import mem_sys_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE    = ADDR_WIDTH'(RAM_BASE_DEFAULT),
  parameter int unsigned           ROM_LATENCY = 1,
  parameter int unsigned           RAM_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,
  output logic                  p0_err_o,
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,
  output logic                  p1_err_o,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  busy_o
);

  localparam int unsigned MaxLat = (ROM_LATENCY > RAM_LATENCY) ? ROM_LATENCY : RAM_LATENCY;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
  localparam logic [CntW-1:0] RomLoad = CntW'(ROM_LATENCY - 1);
  localparam logic [CntW-1:0] RamLoad = CntW'(RAM_LATENCY - 1);

  state_e                state_q;
  logic                  last_gnt_q;
  logic                  port_q;
  logic                  we_q;
  logic                  is_ram_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CntW-1:0]       lat_cnt_q;
  logic                  p0_rvalid_q, p1_rvalid_q;
  logic                  p0_err_q, p1_err_q;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p1_rdata_q;

  logic                  any_req;
  logic                  win_port;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  win_is_ram;
  logic                  grant_ok;
  logic                  rom_write;
  logic                  access_done;
  logic [DATA_WIDTH-1:0] resp_rdata;

  // Winner selection: sole requester wins; on a tie the port not served last wins.
  assign any_req = p0_req_i | p1_req_i;

  always_comb begin
    if (p0_req_i && p1_req_i) begin
      win_port = ~last_gnt_q;
    end else if (p0_req_i) begin
      win_port = PORT_FETCH;
    end else begin
      win_port = PORT_DATA;
    end
  end

  assign win_we    = (win_port == PORT_DATA) ? p1_we_i    : p0_we_i;
  assign win_addr  = (win_port == PORT_DATA) ? p1_addr_i  : p0_addr_i;
  assign win_wdata = (win_port == PORT_DATA) ? p1_wdata_i : p0_wdata_i;

  mem_region_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_BASE   (RAM_BASE)
  ) u_region_decode (
    .addr   (win_addr),
    .is_ram (win_is_ram)
  );

  // Grant is gated by reset so that every output reads 0 while reset is held.
  assign grant_ok = rst_n_i && (state_q == IDLE) && any_req;
  assign p0_gnt_o = grant_ok && (win_port == PORT_FETCH);
  assign p1_gnt_o = grant_ok && (win_port == PORT_DATA);

  // A ROM write never touches the macro: it finishes after one ACCESS cycle with an error.
  assign rom_write   = we_q & ~is_ram_q;
  assign access_done = rom_write | (lat_cnt_q == '0);
  assign resp_rdata  = we_q ? '0 : (is_ram_q ? ram_rdata_i : rom_rdata_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      last_gnt_q  <= PORT_DATA;
      port_q      <= PORT_FETCH;
      we_q        <= 1'b0;
      is_ram_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_cnt_q   <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      // Completion strobes are single-cycle; they are re-set only on ACCESS exit.
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            port_q     <= win_port;
            we_q       <= win_we;
            addr_q     <= win_addr;
            wdata_q    <= win_wdata;
            is_ram_q   <= win_is_ram;
            last_gnt_q <= win_port;
            lat_cnt_q  <= win_is_ram ? RamLoad : RomLoad;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (access_done) begin
            state_q <= RESP;
            if (port_q == PORT_FETCH) begin
              p0_rvalid_q <= 1'b1;
              p0_rdata_q  <= resp_rdata;
              p0_err_q    <= rom_write;
            end else begin
              p1_rvalid_q <= 1'b1;
              p1_rdata_q  <= resp_rdata;
              p1_err_q    <= rom_write;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - CntW'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign p0_rvalid_o = p0_rvalid_q;
  assign p1_rvalid_o = p1_rvalid_q;
  assign p0_err_o    = p0_err_q;
  assign p1_err_o    = p1_err_q;
  assign p0_rdata_o  = p0_rdata_q;
  assign p1_rdata_o  = p1_rdata_q;

  // Memory side is decoded straight from registered state so it drops with reset.
  assign rom_en_o    = (state_q == ACCESS) && !is_ram_q && !we_q;
  assign rom_addr_o  = rom_en_o ? addr_q : '0;
  assign ram_en_o    = (state_q == ACCESS) && is_ram_q;
  assign ram_we_o    = ram_en_o && we_q;
  assign ram_addr_o  = ram_en_o ? addr_q : '0;
  assign ram_wdata_o = ram_we_o ? wdata_q : '0;

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam logic [31:0] RamBase = 32'h0010_0000;
  localparam logic [31:0] Bad     = 32'hBAD0_BAD0;

  logic        clk, rst_n;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        rom_en, ram_en, ram_we, busy;
  logic [31:0] rom_addr, rom_rdata, ram_addr, ram_wdata, ram_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  // Memory macro models
  logic        rom_fixed;
  logic [31:0] rom_val;
  logic [31:0] ram_arr [32];
  logic [31:0] ram_vld;
  logic        ram_clr;

  // Reference-model RAM image
  logic [31:0] model_mem [32];
  logic [31:0] model_vld;

  mem_port_arbiter u_dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .p0_req_i    (p0_req),
    .p0_we_i     (p0_we),
    .p0_addr_i   (p0_addr),
    .p0_wdata_i  (p0_wdata),
    .p0_gnt_o    (p0_gnt),
    .p0_rvalid_o (p0_rvalid),
    .p0_rdata_o  (p0_rdata),
    .p0_err_o    (p0_err),
    .p1_req_i    (p1_req),
    .p1_we_i     (p1_we),
    .p1_addr_i   (p1_addr),
    .p1_wdata_i  (p1_wdata),
    .p1_gnt_o    (p1_gnt),
    .p1_rvalid_o (p1_rvalid),
    .p1_rdata_o  (p1_rdata),
    .p1_err_o    (p1_err),
    .rom_en_o    (rom_en),
    .rom_addr_o  (rom_addr),
    .rom_rdata_i (rom_rdata),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  function automatic logic [31:0] ram_init(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [4:0] ram_idx(input logic [31:0] a);
    return {a[31], a[5:2]};
  endfunction

  function automatic logic [31:0] ram_peek(input logic [31:0] a);
    return ram_vld[ram_idx(a)] ? ram_arr[ram_idx(a)] : ram_init(a);
  endfunction

  always_comb begin
    rom_rdata = Bad;
    if (rom_en) rom_rdata = rom_fixed ? rom_val : rom_fn(rom_addr);
  end

  always @(posedge clk) begin
    if (ram_clr) begin
      ram_vld <= '0;
    end else if (ram_en && ram_we) begin
      ram_arr[ram_idx(ram_addr)] <= ram_wdata;
      ram_vld[ram_idx(ram_addr)] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    ram_rdata <= (ram_en && !ram_we) ? ram_peek(ram_addr) : Bad;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err,
                         rom_en, ram_en, ram_we, busy}, 0);
    chk({name, "_data"}, p0_rdata | p1_rdata | rom_addr | ram_addr | ram_wdata, 0);
  endtask

  // ---------------- table-driven directed vectors ----------------
  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rom_data;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          rom_cyc;
    int          ram_cyc;
    int          ram_we_cyc;
  } vec_t;

  vec_t        vt[7];
  logic [31:0] last_rd[2];

  task automatic run_table();
    int lat, rc, mc, wc, bad, got;
    logic        rv_err;
    logic [31:0] rv_data;
    for (int i = 0; i < 7; i++) begin
      rom_val = vt[i].rom_data;
      if (vt[i].port) begin
        p1_req = 1'b1; p1_we = vt[i].we; p1_addr = vt[i].addr; p1_wdata = vt[i].wdata;
      end else begin
        p0_req = 1'b1; p0_we = vt[i].we; p0_addr = vt[i].addr; p0_wdata = vt[i].wdata;
      end
      got = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if ((vt[i].port ? p1_gnt : p0_gnt) == 1'b1) begin
          got = 1;
          break;
        end
      end
      chk($sformatf("vec%0d_gnt", i), got, 1);
      @(posedge clk); #1;
      p0_req = 1'b0;
      p1_req = 1'b0;
      lat = 0; rc = 0; mc = 0; wc = 0; bad = 0;
      rv_data = '0; rv_err = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        lat++;
        if (rom_en) begin
          rc++;
          if (rom_addr != vt[i].addr) bad++;
        end
        if (ram_en) begin
          mc++;
          if (ram_addr != vt[i].addr) bad++;
        end
        if (ram_we) begin
          wc++;
          if (ram_wdata != vt[i].wdata) bad++;
        end
        if ((vt[i].port ? p0_rvalid : p1_rvalid) == 1'b1) bad++;
        if ((vt[i].port ? p1_rvalid : p0_rvalid) == 1'b1) begin
          rv_data = vt[i].port ? p1_rdata : p0_rdata;
          rv_err  = vt[i].port ? p1_err : p0_err;
          break;
        end
      end
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_rdata", i), rv_data, vt[i].rdata);
      chk($sformatf("vec%0d_err", i), rv_err, vt[i].err);
      chk($sformatf("vec%0d_rom_en_cycles", i), rc, vt[i].rom_cyc);
      chk($sformatf("vec%0d_ram_en_cycles", i), mc, vt[i].ram_cyc);
      chk($sformatf("vec%0d_ram_we_cycles", i), wc, vt[i].ram_we_cyc);
      chk($sformatf("vec%0d_bus_values", i), bad, 0);
      chk($sformatf("vec%0d_other_rdata_hold", i), vt[i].port ? p0_rdata : p1_rdata,
          last_rd[vt[i].port ? 0 : 1]);
      last_rd[vt[i].port ? 1 : 0] = vt[i].rdata;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- randomized run against transaction-level model ----------------
  task automatic new_req(input int p);
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0, 1:    a = 32'(4 * $urandom_range(0, 15));
      2:       a = 32'h000F_FFFC;
      3, 4:    a = RamBase + 32'(4 * $urandom_range(0, 15));
      default: a = 32'hFFFF_FFFF;
    endcase
    if (p == 0) begin
      p0_req = 1'b1; p0_we = ($urandom_range(0, 2) == 0); p0_addr = a; p0_wdata = $urandom;
    end else begin
      p1_req = 1'b1; p1_we = ($urandom_range(0, 2) == 0); p1_addr = a; p1_wdata = $urandom;
    end
  endtask

  task automatic run_random(input int ncyc);
    int          next_free, resp_cyc, lat;
    logic        last, pend, pport, perr, w, isr, we;
    logic [31:0] pdata, a, wd;
    logic [1:0]  exp_rv, exp_gnt, gs;
    logic        exp_busy;
    last = 1'b1; pend = 1'b0; pport = 1'b0; perr = 1'b0; pdata = '0;
    next_free = 0; resp_cyc = 0;
    model_vld = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      exp_rv = (pend && cyc == resp_cyc) ? (pport ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_rvalid", {p1_rvalid, p0_rvalid}, exp_rv);
      chk("rnd_err", {p1_err, p0_err}, perr ? exp_rv : 2'b00);
      if (exp_rv != 2'b00) begin
        last_rd[pport] = pdata;
        pend = 1'b0;
      end
      chk("rnd_p0_rdata", p0_rdata, last_rd[0]);
      chk("rnd_p1_rdata", p1_rdata, last_rd[1]);
      exp_busy = (cyc < next_free);
      chk("rnd_busy", busy, exp_busy);
      exp_gnt = 2'b00;
      if (!exp_busy && (p0_req || p1_req)) begin
        w = (p0_req && p1_req) ? !last : !p0_req;
        exp_gnt = w ? 2'b10 : 2'b01;
        a   = w ? p1_addr : p0_addr;
        we  = w ? p1_we : p0_we;
        wd  = w ? p1_wdata : p0_wdata;
        isr = (a >= RamBase);
        lat = isr ? 2 : 1;
        resp_cyc  = cyc + lat + 1;
        next_free = cyc + lat + 2;
        if (we) pdata = '0;
        else if (isr) pdata = model_vld[ram_idx(a)] ? model_mem[ram_idx(a)] : ram_init(a);
        else pdata = rom_fn(a);
        if (we && isr) begin
          model_mem[ram_idx(a)] = wd;
          model_vld[ram_idx(a)] = 1'b1;
        end
        perr  = we && !isr;
        pport = w;
        pend  = 1'b1;
        last  = w;
      end
      chk("rnd_gnt", {p1_gnt, p0_gnt}, exp_gnt);
      gs = {p1_gnt, p0_gnt};
      @(posedge clk); #1;
      if (gs[0]) p0_req = 1'b0;
      if (gs[1]) p1_req = 1'b0;
      if (!p0_req && $urandom_range(0, 99) < 50) new_req(0);
      if (!p1_req && $urandom_range(0, 99) < 50) new_req(1);
    end
  endtask

  initial begin
    int          g, multi, cnt, got;
    int          gcyc[4];
    logic [3:0]  gp;

    rst_n = 1'b0; ram_clr = 1'b1; rom_fixed = 1'b0; rom_val = '0;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (2) @(posedge clk); #1;
    ram_clr = 1'b0;
    check_zero("reset");
    rst_n = 1'b1;

    // Both ports request continuously: strict alternation, one grant every 3 cycles.
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h20;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h24;
    g = 0; multi = 0; gp = '0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      @(negedge clk);
      if (p0_gnt && p1_gnt) multi++;
      if (p0_gnt || p1_gnt) begin
        gp[g]   = p1_gnt;
        gcyc[g] = c;
        g++;
      end
    end
    chk("alt_grant_count", g, 4);
    chk("alt_dual_grant", multi, 0);
    if (g == 4) begin
      chk("alt_first_grant_cycle", gcyc[0], 0);
      chk("alt_order", gp, 4'b1010);
      for (int i = 1; i < 4; i++) chk($sformatf("alt_gap%0d", i), gcyc[i] - gcyc[i-1], 3);
    end
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Reset in the middle of a RAM read: outputs clear at once, no completion follows.
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h0010_0008;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (p1_gnt) begin
        got = 1;
        break;
      end
    end
    chk("rst_seq_gnt", got, 1);
    @(posedge clk); #1;
    chk("rst_seq_ram_en_before", ram_en, 1);
    p0_req = 1'b1;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid_access");
    @(posedge clk); #1;
    check_zero("rst_held");
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (p0_rvalid || p1_rvalid || busy) cnt++;
    end
    chk("rst_no_rvalid", cnt, 0);
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h30;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h34;
    @(negedge clk);
    chk("rst_first_tie", {p1_gnt, p0_gnt}, 2'b01);
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Directed vectors
    vt[0] = '{port: 1'b0, we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0, rom_data: 32'hDEAD_BEEF,
              lat: 2, rdata: 32'hDEAD_BEEF, err: 1'b0, rom_cyc: 1, ram_cyc: 0, ram_we_cyc: 0};
    vt[1] = '{port: 1'b1, we: 1'b1, addr: 32'h0010_0004, wdata: 32'hA5A5_A5A5, rom_data: 32'h0,
              lat: 3, rdata: 32'h0, err: 1'b0, rom_cyc: 0, ram_cyc: 2, ram_we_cyc: 2};
    vt[2] = '{port: 1'b1, we: 1'b1, addr: 32'h0000_0100, wdata: 32'h1111_2222, rom_data: 32'h0,
              lat: 2, rdata: 32'h0, err: 1'b1, rom_cyc: 0, ram_cyc: 0, ram_we_cyc: 0};
    vt[3] = '{port: 1'b0, we: 1'b0, addr: 32'h000F_FFFC, wdata: 32'h0, rom_data: 32'h1234_5678,
              lat: 2, rdata: 32'h1234_5678, err: 1'b0, rom_cyc: 1, ram_cyc: 0, ram_we_cyc: 0};
    vt[4] = '{port: 1'b1, we: 1'b0, addr: 32'h0010_0000, wdata: 32'h0, rom_data: 32'h0,
              lat: 3, rdata: 32'h5A4A_0000, err: 1'b0, rom_cyc: 0, ram_cyc: 2, ram_we_cyc: 0};
    vt[5] = '{port: 1'b0, we: 1'b0, addr: 32'h0010_0004, wdata: 32'h0, rom_data: 32'h0,
              lat: 3, rdata: 32'hA5A5_A5A5, err: 1'b0, rom_cyc: 0, ram_cyc: 2, ram_we_cyc: 0};
    vt[6] = '{port: 1'b1, we: 1'b0, addr: 32'hFFFF_FFFF, wdata: 32'h0, rom_data: 32'h0,
              lat: 3, rdata: 32'hA5A5_FFFF, err: 1'b0, rom_cyc: 0, ram_cyc: 2, ram_we_cyc: 0};
    last_rd[0] = rom_fn(32'h30);
    last_rd[1] = 32'h0;
    rom_fixed  = 1'b1;
    run_table();

    // Randomized traffic from a fresh reset
    rom_fixed = 1'b0;
    rst_n   = 1'b0;
    ram_clr = 1'b1;
    @(posedge clk); #1;
    ram_clr = 1'b0;
    rst_n   = 1'b1;
    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
